// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, CTRL layout and default window base shared by the
// mmio_gpio_bridge files.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_0000;

    localparam logic [3:0] OFF_SWITCH      = 4'h0;
    localparam logic [3:0] OFF_BTN_LEVEL   = 4'h1;
    localparam logic [3:0] OFF_BTN_EVENT   = 4'h2;
    localparam logic [3:0] OFF_LED         = 4'h3;
    localparam logic [3:0] OFF_SEG         = 4'h4;
    localparam logic [3:0] OFF_TCNT        = 4'h5;
    localparam logic [3:0] OFF_TCMP        = 4'h6;
    localparam logic [3:0] OFF_CTRL        = 4'h7;
    localparam logic [3:0] OFF_STATUS      = 4'h8;
    localparam logic [3:0] OFF_BTN_RELEASE = 4'h9;

    localparam int CTRL_TIMER_EN   = 0;
    localparam int CTRL_BTN_IRQ_EN = 1;
    localparam int CTRL_TMR_IRQ_EN = 2;
    localparam int CTRL_AUTORELOAD = 3;

    typedef struct packed {
        logic autoreload;
        logic tmr_irq_en;
        logic btn_irq_en;
        logic timer_en;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [31:0] word);
        ctrl_t c;
        c.timer_en   = word[CTRL_TIMER_EN];
        c.btn_irq_en = word[CTRL_BTN_IRQ_EN];
        c.tmr_irq_en = word[CTRL_TMR_IRQ_EN];
        c.autoreload = word[CTRL_AUTORELOAD];
        return c;
    endfunction

endpackage

// File: rtl/mmio_gpio_bridge_edge_capture.sv
// edge_capture: per-bit sticky edge flags (rising or falling) with write-1-to-clear;
// an edge arriving in the same cycle as its clear keeps the flag set.
module edge_capture
    import mmio_pkg::*;
#(
    parameter int W    = 5,
    parameter bit RISE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    input  logic [W-1:0] clr_mask,
    input  logic         clr_en,
    output logic [W-1:0] events
);

    logic [W-1:0] r_prev;
    logic [W-1:0] r_events;
    logic [W-1:0] w_edge;
    logic [W-1:0] w_clr;

    assign w_edge = RISE ? (level & ~r_prev) : (~level & r_prev);
    assign w_clr  = clr_en ? clr_mask : {W{1'b0}};

    // Previous-sample register and sticky flags; OR-ing the edge after the clear gives set-wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= {W{1'b0}};
            r_events <= {W{1'b0}};
        end else begin
            r_prev   <= level;
            r_events <= (r_events & ~w_clr) | w_edge;
        end
    end

    assign events = r_events;

endmodule

// File: rtl/mmio_gpio_bridge.sv
// mmio_gpio_bridge: CPU MMIO window onto switches, buttons, LEDs, seven-segment and a
// compare timer. Define MMIO_BTN_FALL_EN to add the BTN_RELEASE falling-edge register.
module mmio_gpio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE = DEFAULT_BASE,
    parameter int          NBTN = 5,
    parameter int          NSW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            we,
    input  logic            re,
    output logic [31:0]     rdata,
    output logic            rvalid,
    input  logic [NSW-1:0]  switch,
    input  logic [NBTN-1:0] button,
    output logic [15:0]     led,
    output logic [31:0]     seg_value,
    output logic            irq
);

    logic            w_hit;
    logic [3:0]      w_off;
    logic            w_wr;
    logic            w_rd;
    logic [31:0]     w_rd_mux;
    logic [NBTN-1:0] w_rise_evt;
    logic            w_btn_any;
    logic            w_tmr_hit;
    logic            w_unused;

    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic [15:0] r_led;
    logic [31:0] r_seg;
    logic [31:0] r_tcnt;
    logic [31:0] r_tcmp;
    ctrl_t       r_ctrl;
    logic        r_status;
    logic        r_irq;

    assign w_hit     = (addr[31:6] == BASE[31:6]);
    assign w_off     = addr[5:2];
    assign w_wr      = we & w_hit;
    assign w_rd      = re & w_hit;
    assign w_tmr_hit = r_ctrl.timer_en & (r_tcnt == r_tcmp);
    assign w_unused  = ^addr[1:0];

    edge_capture #(.W(NBTN), .RISE(1'b1)) u_rise (
        .clk      (clk),
        .rst      (rst),
        .level    (button),
        .clr_mask (wdata[NBTN-1:0]),
        .clr_en   (w_wr & (w_off == OFF_BTN_EVENT)),
        .events   (w_rise_evt)
    );

`ifdef MMIO_BTN_FALL_EN
    logic [NBTN-1:0] w_fall_evt;

    edge_capture #(.W(NBTN), .RISE(1'b0)) u_fall (
        .clk      (clk),
        .rst      (rst),
        .level    (button),
        .clr_mask (wdata[NBTN-1:0]),
        .clr_en   (w_wr & (w_off == OFF_BTN_RELEASE)),
        .events   (w_fall_evt)
    );

    assign w_btn_any = (|w_rise_evt) | (|w_fall_evt);
`else
    assign w_btn_any = |w_rise_evt;
`endif

    // Read mux sees pre-write register values, so a same-cycle store does not leak into the load.
    always_comb begin
        w_rd_mux = 32'h0;
        case (w_off)
            OFF_SWITCH:      w_rd_mux = 32'(switch);
            OFF_BTN_LEVEL:   w_rd_mux = 32'(button);
            OFF_BTN_EVENT:   w_rd_mux = 32'(w_rise_evt);
            OFF_LED:         w_rd_mux = {16'h0, r_led};
            OFF_SEG:         w_rd_mux = r_seg;
            OFF_TCNT:        w_rd_mux = r_tcnt;
            OFF_TCMP:        w_rd_mux = r_tcmp;
            OFF_CTRL:        w_rd_mux = {28'h0, r_ctrl};
            OFF_STATUS:      w_rd_mux = {31'h0, r_status};
`ifdef MMIO_BTN_FALL_EN
            OFF_BTN_RELEASE: w_rd_mux = 32'(w_fall_evt);
`endif
            default:         w_rd_mux = 32'h0;
        endcase
    end

    // Load response pipeline: rdata only updates on a valid in-window load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= 32'h0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // Plain RW registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led  <= 16'h0;
            r_seg  <= 32'h0;
            r_tcmp <= 32'hFFFF_FFFF;
            r_ctrl <= ctrl_from_word(32'h0);
        end else if (w_wr) begin
            case (w_off)
                OFF_LED:  r_led  <= wdata[15:0];
                OFF_SEG:  r_seg  <= wdata;
                OFF_TCMP: r_tcmp <= wdata;
                OFF_CTRL: r_ctrl <= ctrl_from_word(wdata);
                default:  r_led  <= r_led;
            endcase
        end else begin
            r_led <= r_led;
        end
    end

    // Timer: a CPU write to TCNT overrides counting; a compare hit beats a STATUS clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt   <= 32'h0;
            r_status <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_TCNT)) begin
                r_tcnt <= wdata;
            end else if (r_ctrl.timer_en) begin
                r_tcnt <= (w_tmr_hit && r_ctrl.autoreload) ? 32'h0 : r_tcnt + 32'h1;
            end else begin
                r_tcnt <= r_tcnt;
            end

            if (w_tmr_hit) begin
                r_status <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && wdata[0]) begin
                r_status <= 1'b0;
            end else begin
                r_status <= r_status;
            end
        end
    end

    // Interrupt is a registered OR of the enabled sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_btn_any & r_ctrl.btn_irq_en) | (r_status & r_ctrl.tmr_irq_en);
        end
    end

    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign led       = r_led;
    assign seg_value = r_seg;
    assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_gpio_bridge.sv
// tb_mmio_gpio_bridge: directed plus random MMIO traffic against a behavioural model;
// expected load data goes through a scoreboard queue popped by a separate monitor.
module tb_mmio_gpio_bridge;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic [15:0] switch;
    logic [4:0]  button;
    logic [15:0] led;
    logic [31:0] seg_value;
    logic        irq;

    always #5 clk = ~clk;

    mmio_gpio_bridge #(.BASE(BASE), .NBTN(5), .NSW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .switch    (switch),
        .button    (button),
        .led       (led),
        .seg_value (seg_value),
        .irq       (irq)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_last_rd = 32'h0;

    // Reference state of the register file
    logic [15:0] m_led;
    logic [31:0] m_seg, m_tcnt, m_tcmp;
    logic [3:0]  m_ctrl;
    logic        m_status, m_irq;
    logic [4:0]  m_evt, m_prev;

    logic [31:0] a_r, d_r;
    int          op;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_led = 16'h0; m_seg = 32'h0; m_tcnt = 32'h0; m_tcmp = 32'hFFFF_FFFF;
        m_ctrl = 4'h0; m_status = 1'b0; m_irq = 1'b0; m_evt = 5'h0; m_prev = 5'h0;
    endfunction

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0:       return {16'h0, switch};
            1:       return {27'h0, button};
            2:       return {27'h0, m_evt};
            3:       return {16'h0, m_led};
            4:       return m_seg;
            5:       return m_tcnt;
            6:       return m_tcmp;
            7:       return {28'h0, m_ctrl};
            8:       return {31'h0, m_status};
            default: return 32'h0;
        endcase
    endfunction

    // Apply one cycle of CPU access and input levels to the model.
    task automatic step_model(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic hit, wr, tmr_hit, irq_n;
        int   off;
        hit = (a[31:6] == BASE[31:6]);
        off = int'(a[5:2]);
        wr  = w && hit;
        if (r && hit) exp_q.push_back(model_read(off));
        irq_n   = ((m_evt != 5'h0) && m_ctrl[1]) || (m_status && m_ctrl[2]);
        tmr_hit = m_ctrl[0] && (m_tcnt == m_tcmp);
        m_evt   = (m_evt & ~((wr && off == 2) ? d[4:0] : 5'h0)) | (button & ~m_prev);
        m_prev  = button;
        if (tmr_hit) m_status = 1'b1;
        else if (wr && off == 8 && d[0]) m_status = 1'b0;
        if (wr && off == 5) m_tcnt = d;
        else if (m_ctrl[0]) m_tcnt = (tmr_hit && m_ctrl[3]) ? 32'h0 : m_tcnt + 32'h1;
        if (wr) begin
            case (off)
                3:       m_led  = d[15:0];
                4:       m_seg  = d;
                6:       m_tcmp = d;
                7:       m_ctrl = d[3:0];
                default: ;
            endcase
        end
        m_irq = irq_n;
    endtask

    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        re = r; we = w; addr = a; wdata = d;
        step_model(r, w, a, d);
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        check("led", {16'h0, led}, {16'h0, m_led});
        check("seg_value", seg_value, m_seg);
        check("irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic do_reset(input logic with_re);
        rst = 1'b1; re = with_re; we = 1'b0; addr = BASE + 32'h18; wdata = 32'h0;
        @(posedge clk); #1;
        m_last_rd = 32'h0;
        re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("reset_rvalid", {31'h0, rvalid}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_seg", seg_value, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
    endtask

    // Scoreboard monitor: each rvalid pops one expected value; otherwise rdata must hold.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rvalid_unexpected: got rvalid=1 expected rvalid=0 at %0t", $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("rdata", rdata, e);
                m_last_rd = e;
            end
        end else begin
            check("rdata_hold", rdata, m_last_rd);
        end
    end

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        switch = 16'h0; button = 5'h0;
        model_reset();
        do_reset(1'b0);

        cycle(1'b1, 1'b0, BASE + 32'h18, 32'h0);
        cycle(1'b1, 1'b0, BASE + 32'h3C, 32'h0);
        switch = 16'hA5A5;
        cycle(1'b1, 1'b0, BASE, 32'h0);
        cycle(1'b1, 1'b0, 32'h0000_1000, 32'h0);

        button = 5'b00100;
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, BASE + 32'h08, 32'h0);
        button = 5'b00101;
        cycle(1'b0, 1'b1, BASE + 32'h08, 32'h4);
        cycle(1'b1, 1'b0, BASE + 32'h08, 32'h0);
        cycle(0, 1, BASE + 32'h08, 32'h1F);

        cycle(1'b0, 1'b1, BASE + 32'h18, 32'h5);
        cycle(1'b0, 1'b1, BASE + 32'h1C, 32'hD);
        repeat (10) cycle(1'b1, 1'b0, BASE + 32'h14, 32'h0);
        cycle(1'b1, 1'b0, BASE + 32'h20, 32'h0);
        cycle(1'b0, 1'b1, BASE + 32'h1C, 32'h4);
        cycle(1'b0, 1'b1, BASE + 32'h20, 32'h1);
        repeat (3) cycle(1'b1, 1'b0, BASE + 32'h20, 32'h0);

        cycle(1'b0, 1'b1, BASE + 32'h0C, 32'hBEEF);
        cycle(1'b1, 1'b1, BASE + 32'h0C, 32'h1234);
        cycle(1'b1, 1'b0, BASE + 32'h0C, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) button = 5'($urandom);
            if ($urandom_range(0, 7) == 0) switch = 16'($urandom);
            op = int'($urandom_range(0, 15));
            a_r = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'(op * 4);
            d_r = (op == 5 || op == 6) ? 32'($urandom_range(0, 30)) : $urandom;
            cycle(1'($urandom), 1'($urandom), a_r, d_r);
        end

        button = 5'b00001;
        cycle(1'b1, 1'b0, BASE + 32'h14, 32'h0);
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, BASE + 32'(k * 4), 32'h0);

        repeat (3) cycle(1'b0, 1'b0, 32'h0, 32'h0);
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
